// File: rtl/vdc_pkg.sv
// Shared definitions for the VDC block-transfer engine.
//   blt_state_t : operation sequencer states
//   VDC_R_*     : VDC register indices decoded by the blitter
package vdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_DATA,
    FILL,
    CP_RD,
    CP_DATA,
    CP_WR
  } blt_state_t;

  localparam logic [7:0] VDC_R_UAH = 8'd18;
  localparam logic [7:0] VDC_R_UAL = 8'd19;
  localparam logic [7:0] VDC_R_WC  = 8'd30;
  localparam logic [7:0] VDC_R_DA  = 8'd31;
  localparam logic [7:0] VDC_R_BAH = 8'd32;
  localparam logic [7:0] VDC_R_BAL = 8'd33;

endpackage

// File: rtl/vdc_memreq.sv
// Request register for the VRAM request/grant port.
// Holds mem_req/we/addr/wdata stable until granted, then drops the request
// unless a new one is loaded in the same cycle (back-to-back).
//   clk_i, reset_n_i, enable_i : clock, sync active-low reset, clock enable
//   load_i, we_i, addr_i, wdata_i : new request from the sequencer
//   gnt_i                      : grant from the arbiter
//   req_o, we_o, addr_o, wdata_o : registered request towards VRAM
//   done_o                     : transfer happens this cycle (req && gnt)
//   rvalid_o                   : read data valid (cycle after a granted read)
module vdc_memreq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              gnt_i,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              done_o,
  output logic              rvalid_o
);

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rvalid_q;

  assign done_o = req_q & gnt_i;

  always_ff @(posedge clk_i) begin
    if (enable_i) begin
      if (!reset_n_i) begin
        req_q    <= 1'b0;
        we_q     <= 1'b0;
        addr_q   <= '0;
        wdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= done_o & ~we_q;
        // The sequencer only loads when no request is pending or the
        // pending one is being granted, so a request is never withdrawn.
        if (load_i) begin
          req_q   <= 1'b1;
          we_q    <= we_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
        end else if (done_o) begin
          req_q <= 1'b0;
        end
      end
    end
  end

  assign req_o    = req_q;
  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/vdc_blitter.sv
// CPU-side block-transfer engine for VDC video RAM.
// Decodes VDC register accesses (UA 18/19, WC 30, DA 31, BA 32/33) and runs
// single-word read/write, fill and copy through a request/grant port.
//   clk, reset_n, enable        : clock, sync active-low reset, clock enable
//   reg_sel/reg_wdata/reg_wr/reg_rd : CPU register access
//   copy_mode                   : 1 = copy, 0 = fill (sampled on WC write)
//   mem_req/mem_we/mem_addr/mem_wdata, mem_gnt, mem_rdata : VRAM port
//   ua, ba, wc, da              : architectural registers
//   busy                        : operation in progress
module vdc_blitter
  import vdc_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic              copy_mode,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ua,
  output logic [ADDR_W-1:0] ba,
  output logic [CNT_W-1:0]  wc,
  output logic [DATA_W-1:0] da,
  output logic              busy
);

  blt_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ua_q, ua_d;
  logic [ADDR_W-1:0] ba_q, ba_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] da_q, da_d;
  logic              busy_q;

  logic              ld;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              done;
  logic              rvalid;

  vdc_memreq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_memreq (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .enable_i  (enable),
    .load_i    (ld),
    .we_i      (ld_we),
    .addr_i    (ld_addr),
    .wdata_i   (ld_wdata),
    .gnt_i     (mem_gnt),
    .req_o     (mem_req),
    .we_o      (mem_we),
    .addr_o    (mem_addr),
    .wdata_o   (mem_wdata),
    .done_o    (done),
    .rvalid_o  (rvalid)
  );

  always_comb begin
    state_d  = state_q;
    ua_d     = ua_q;
    ba_d     = ba_q;
    wc_d     = wc_q;
    rem_d    = rem_q;
    da_d     = da_q;
    ld       = 1'b0;
    ld_we    = 1'b0;
    ld_addr  = ua_q;
    ld_wdata = da_q;

    case (state_q)
      IDLE: begin
        if (reg_wr) begin
          case (reg_sel)
            VDC_R_UAH: begin
              ua_d[ADDR_W-1:8] = (ADDR_W-8)'(reg_wdata);
              state_d = RD_REQ;
              ld      = 1'b1;
              ld_addr = ua_d;
            end
            VDC_R_UAL: begin
              ua_d[7:0] = 8'(reg_wdata);
              state_d = RD_REQ;
              ld      = 1'b1;
              ld_addr = ua_d;
            end
            VDC_R_DA: begin
              da_d     = reg_wdata;
              state_d  = WR;
              ld       = 1'b1;
              ld_we    = 1'b1;
              ld_wdata = reg_wdata;
            end
            VDC_R_WC: begin
              wc_d  = CNT_W'(reg_wdata);
              rem_d = CNT_W'(reg_wdata);
              ld    = 1'b1;
              if (copy_mode) begin
                state_d = CP_RD;
                ld_addr = ba_q;
              end else begin
                state_d = FILL;
                ld_we   = 1'b1;
              end
            end
            VDC_R_BAH: ba_d[ADDR_W-1:8] = (ADDR_W-8)'(reg_wdata);
            VDC_R_BAL: ba_d[7:0]        = 8'(reg_wdata);
            default: ;
          endcase
        end else if (reg_rd && (reg_sel == VDC_R_DA)) begin
          ua_d    = ua_q + ADDR_W'(1);
          state_d = RD_REQ;
          ld      = 1'b1;
          ld_addr = ua_d;
        end
      end

      WR: begin
        if (done) begin
          ua_d    = ua_q + ADDR_W'(1);
          state_d = RD_REQ;
          ld      = 1'b1;
          ld_addr = ua_d;
        end
      end

      RD_REQ: begin
        if (done) state_d = RD_DATA;
      end

      RD_DATA: begin
        if (rvalid) begin
          da_d    = mem_rdata;
          state_d = IDLE;
        end
      end

      // rem == 0 wraps to all-ones, giving 2^CNT_W words.
      FILL: begin
        if (done) begin
          ua_d  = ua_q + ADDR_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
          end else begin
            ld      = 1'b1;
            ld_we   = 1'b1;
            ld_addr = ua_d;
          end
        end
      end

      CP_RD: begin
        if (done) begin
          ba_d    = ba_q + ADDR_W'(1);
          state_d = CP_DATA;
        end
      end

      // Write request takes the read word directly since da updates on
      // the same edge.
      CP_DATA: begin
        if (rvalid) begin
          da_d     = mem_rdata;
          state_d  = CP_WR;
          ld       = 1'b1;
          ld_we    = 1'b1;
          ld_wdata = mem_rdata;
        end
      end

      CP_WR: begin
        if (done) begin
          ua_d  = ua_q + ADDR_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = CP_RD;
            ld      = 1'b1;
            ld_addr = ba_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enable) begin
      if (!reset_n) begin
        state_q <= IDLE;
        ua_q    <= '0;
        ba_q    <= '0;
        wc_q    <= '0;
        rem_q   <= '0;
        da_q    <= '0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        ua_q    <= ua_d;
        ba_q    <= ba_d;
        wc_q    <= wc_d;
        rem_q   <= rem_d;
        da_q    <= da_d;
        busy_q  <= (state_d != IDLE);
      end
    end
  end

  assign ua   = ua_q;
  assign ba   = ba_q;
  assign wc   = wc_q;
  assign da   = da_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_vdc_blitter.sv
// Directed bench for vdc_blitter with a behavioural VRAM model.
module tb_vdc_blitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  reg_sel;
  logic [7:0]  reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic        copy_mode;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic [15:0] ua;
  logic [15:0] ba;
  logic [7:0]  wc;
  logic [7:0]  da;
  logic        busy;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [7:0]  ram [0:65535];
  logic [7:0]  rdata_q;
  logic [15:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  vdc_blitter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .reg_sel   (reg_sel),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .copy_mode (copy_mode),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .ua        (ua),
    .ba        (ba),
    .wc        (wc),
    .da        (da),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = rdata_q;

  // VRAM model: one transfer per granted, enabled cycle.
  always @(posedge clk) begin
    if (enable && reset_n && mem_req === 1'b1 && mem_gnt) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
        wlog_a.push_back(mem_addr);
        wlog_d.push_back(mem_wdata);
      end else begin
        rdata_q <= ram[mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [7:0] sel, input logic [7:0] data);
    reg_sel   = sel;
    reg_wdata = data;
    reg_wr    = 1'b1;
    tick();
    reg_wr    = 1'b0;
  endtask

  // Counts cycles with busy high; optional alternate grant starting low.
  task automatic run_busy(input bit stall, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      if (stall) mem_gnt = cyc[0];
      cyc++;
      tick();
    end
    mem_gnt = 1'b1;
  endtask

  initial begin
    int cyc;
    int n;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1234] = 8'h77;
    ram[16'h1235] = 8'h5A;
    ram[16'h1236] = 8'hC3;
    ram[16'hFFFE] = 8'h55;
    rdata_q   = 8'h00;
    reset_n   = 1'b0;
    enable    = 1'b1;
    reg_sel   = 8'h00;
    reg_wdata = 8'h00;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    copy_mode = 1'b0;
    mem_gnt   = 1'b1;
    tick(); tick(); tick();

    // Reset state
    chk("rst_ua", ua, 32'h0);
    chk("rst_ba", ba, 32'h0);
    chk("rst_wc", wc, 32'h0);
    chk("rst_da", da, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_req", mem_req, 32'h0);
    reset_n = 1'b1;
    tick();

    // Clock enable low: strobe ignored
    enable = 1'b0;
    wr_reg(8'd19, 8'h99);
    enable = 1'b1;
    tick();
    chk("en_low_ua", ua, 32'h0);
    chk("en_low_busy", busy, 32'h0);

    // UA write
    wr_reg(8'd18, 8'h12);
    run_busy(1'b0, cyc);
    wr_reg(8'd19, 8'h34);
    chk("uaw_busy_rise", busy, 32'h1);
    run_busy(1'b0, cyc);
    chk("uaw_cycles", cyc, 32'd2);
    chk("uaw_ua", ua, 32'h1234);
    chk("uaw_da", da, 32'h77);

    // DA write
    wlog_a.delete(); wlog_d.delete();
    wr_reg(8'd31, 8'hAB);
    run_busy(1'b0, cyc);
    chk("daw_cycles", cyc, 32'd3);
    chk("daw_nwr", wlog_a.size(), 32'd1);
    if (wlog_a.size() >= 1) begin
      chk("daw_addr", wlog_a[0], 32'h1234);
      chk("daw_data", wlog_d[0], 32'hAB);
    end
    chk("daw_ua", ua, 32'h1235);
    chk("daw_da", da, 32'h5A);

    // Data register read
    reg_sel = 8'd31;
    reg_rd  = 1'b1;
    tick();
    reg_rd  = 1'b0;
    run_busy(1'b0, cyc);
    chk("dar_cycles", cyc, 32'd2);
    chk("dar_ua", ua, 32'h1236);
    chk("dar_da", da, 32'hC3);

    // Fill with stalls across the address wrap
    wr_reg(8'd18, 8'hFF); run_busy(1'b0, cyc);
    wr_reg(8'd19, 8'hFD); run_busy(1'b0, cyc);
    wr_reg(8'd31, 8'h55); run_busy(1'b0, cyc);
    chk("fs_setup_ua", ua, 32'hFFFE);
    chk("fs_setup_da", da, 32'h55);
    wlog_a.delete(); wlog_d.delete();
    wr_reg(8'd30, 8'd4);
    run_busy(1'b1, cyc);
    chk("fs_cycles", cyc, 32'd8);
    chk("fs_nwr", wlog_a.size(), 32'd4);
    if (wlog_a.size() == 4) begin
      chk("fs_a0", wlog_a[0], 32'hFFFE);
      chk("fs_a1", wlog_a[1], 32'hFFFF);
      chk("fs_a2", wlog_a[2], 32'h0000);
      chk("fs_a3", wlog_a[3], 32'h0001);
      chk("fs_d3", wlog_d[3], 32'h55);
    end
    chk("fs_ua", ua, 32'h0002);
    chk("fs_wc", wc, 32'd4);

    // Full-length fill (count 0)
    wlog_a.delete(); wlog_d.delete();
    wr_reg(8'd30, 8'd0);
    run_busy(1'b0, cyc);
    chk("ff_cycles", cyc, 32'd256);
    chk("ff_nwr", wlog_a.size(), 32'd256);
    if (wlog_a.size() == 256) begin
      chk("ff_first", wlog_a[0], 32'h0002);
      chk("ff_last", wlog_a[255], 32'h0101);
    end
    chk("ff_ua", ua, 32'h0102);
    chk("ff_wc", wc, 32'h0);

    // Copy
    ram[16'h0100] = 8'd1;
    ram[16'h0101] = 8'd2;
    ram[16'h0102] = 8'd3;
    wr_reg(8'd32, 8'h01);
    chk("baw_no_busy", busy, 32'h0);
    wr_reg(8'd33, 8'h00);
    chk("baw_ba", ba, 32'h0100);
    wr_reg(8'd18, 8'h02); run_busy(1'b0, cyc);
    wr_reg(8'd19, 8'h00); run_busy(1'b0, cyc);
    wlog_a.delete(); wlog_d.delete();
    copy_mode = 1'b1;
    wr_reg(8'd30, 8'd3);
    copy_mode = 1'b0;
    run_busy(1'b0, cyc);
    chk("cp_cycles", cyc, 32'd9);
    chk("cp_nwr", wlog_a.size(), 32'd3);
    if (wlog_a.size() == 3) begin
      chk("cp_a0", wlog_a[0], 32'h0200);
      chk("cp_d0", wlog_d[0], 32'd1);
      chk("cp_a2", wlog_a[2], 32'h0202);
      chk("cp_d1", wlog_d[1], 32'd2);
      chk("cp_d2", wlog_d[2], 32'd3);
    end
    chk("cp_ba", ba, 32'h0103);
    chk("cp_ua", ua, 32'h0203);
    chk("cp_da", da, 32'd3);
    chk("cp_wc", wc, 32'd3);

    // Busy lockout: UA write during a fill of 10 is dropped
    wlog_a.delete(); wlog_d.delete();
    wr_reg(8'd30, 8'd10);
    tick(); tick();
    wr_reg(8'd18, 8'h77);
    run_busy(1'b0, cyc);
    chk("lk_cycles", cyc + 3, 32'd10);
    chk("lk_ua", ua, 32'h020D);
    chk("lk_nwr", wlog_a.size(), 32'd10);
    chk("lk_wc", wc, 32'd10);
    chk("lk_da", da, 32'd3);

    // Reset mid-copy
    wlog_a.delete(); wlog_d.delete();
    copy_mode = 1'b1;
    wr_reg(8'd30, 8'd20);
    copy_mode = 1'b0;
    n = 0;
    while (wlog_a.size() < 5 && n < 200) begin
      n++;
      tick();
    end
    chk("mr_reach5", wlog_a.size(), 32'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr_ua", ua, 32'h0);
    chk("mr_ba", ba, 32'h0);
    chk("mr_wc", wc, 32'h0);
    chk("mr_da", da, 32'h0);
    chk("mr_busy", busy, 32'h0);
    chk("mr_req", mem_req, 32'h0);
    chk("mr_we", mem_we, 32'h0);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_wdata", mem_wdata, 32'h0);
    repeat (10) tick();
    chk("mr_req_after", mem_req, 32'h0);
    chk("mr_busy_after", busy, 32'h0);
    chk("mr_nwr_after", wlog_a.size(), 32'd5);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
